// File: rtl/morse_receiver.sv
// -----------------------------------------------------------------------------
// morse_receiver
//   Decodes an on/off Morse keying line back into a 5-bit letter index
//   (A=0 ... Z=25). Mark and space durations are measured in clock cycles
//   against a threshold of two Morse units. This tolerates phase offset and
//   modest rate mismatch with the transmitter.
//
// Parameters
//   UNIT_CYCLES     clock cycles per Morse time unit (2 ... 2^29)
//
// Ports
//   clk_i           system clock, all state on rising edge
//   rst_ni          asynchronous active-low reset
//   key_in_i        raw keying line, 1 = mark; asynchronous to clk_i
//   letter_o        last successfully decoded letter index, held between decodes
//   letter_valid_o  one-cycle pulse: letter_o has just been updated
//   error_o         one-cycle pulse: letter ended with an illegal element sequence
//   busy_o          high while a letter is in progress
// -----------------------------------------------------------------------------
module morse_receiver #(
   parameter int unsigned UNIT_CYCLES = 25000000
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       key_in_i,
   output logic [4:0] letter_o,
   output logic       letter_valid_o,
   output logic       error_o,
   output logic       busy_o
);

   // Dot/dash and gap/letter-end boundary: two units.
   localparam logic [31:0] THRESH = 32'(2 * UNIT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MARK,
      S_SPACE,
      S_DECODE
   } state_e;

   state_e      state_q;
   logic        key_meta_q;
   logic        key_sync_q;
   logic [31:0] cnt_q;
   logic [3:0]  pat_q;
   logic [2:0]  len_q;
   logic        ovf_q;
   logic [4:0]  letter_q;
   logic        valid_q;
   logic        error_q;
   logic        busy_q;

   logic [31:0] cnt_d;
   logic        is_dash;
   logic        hit;
   logic [4:0]  idx;

   // Two-flop synchronizer. Both edges see the same latency, so the
   // measured durations equal the true durations.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         key_meta_q <= 1'b0;
         key_sync_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let both flops sample the
         // pre-edge values, which forms a true two-stage pipeline.
         key_meta_q <= key_in_i;
         key_sync_q <= key_meta_q;
      end
   end

   // Saturating increment. A mark that never ends parks at all-ones
   // instead of wrapping back into the dot range.
   assign cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
   assign is_dash = (cnt_q >= THRESH);

   // Code lookup. The first-received element sits at bit len-1.
   // pat_q starts cleared and shifts left, so unused upper bits are zero.
   always_comb begin
      // NOTE: defaults ahead of the case keep this purely combinational
      // (no latch) for every unlisted (len, pat) combination.
      hit = 1'b1;
      idx = 5'd0;
      case ({len_q, pat_q})
         {3'd1, 4'b0000}: idx = 5'd4;   // E .
         {3'd1, 4'b0001}: idx = 5'd19;  // T -
         {3'd2, 4'b0001}: idx = 5'd0;   // A .-
         {3'd2, 4'b0000}: idx = 5'd8;   // I ..
         {3'd2, 4'b0011}: idx = 5'd12;  // M --
         {3'd2, 4'b0010}: idx = 5'd13;  // N -.
         {3'd3, 4'b0100}: idx = 5'd3;   // D -..
         {3'd3, 4'b0110}: idx = 5'd6;   // G --.
         {3'd3, 4'b0101}: idx = 5'd10;  // K -.-
         {3'd3, 4'b0111}: idx = 5'd14;  // O ---
         {3'd3, 4'b0010}: idx = 5'd17;  // R .-.
         {3'd3, 4'b0000}: idx = 5'd18;  // S ...
         {3'd3, 4'b0001}: idx = 5'd20;  // U ..-
         {3'd3, 4'b0011}: idx = 5'd22;  // W .--
         {3'd4, 4'b1000}: idx = 5'd1;   // B -...
         {3'd4, 4'b1010}: idx = 5'd2;   // C -.-.
         {3'd4, 4'b0010}: idx = 5'd5;   // F ..-.
         {3'd4, 4'b0000}: idx = 5'd7;   // H ....
         {3'd4, 4'b0111}: idx = 5'd9;   // J .---
         {3'd4, 4'b0100}: idx = 5'd11;  // L .-..
         {3'd4, 4'b0110}: idx = 5'd15;  // P .--.
         {3'd4, 4'b1101}: idx = 5'd16;  // Q --.-
         {3'd4, 4'b0001}: idx = 5'd21;  // V ...-
         {3'd4, 4'b1001}: idx = 5'd23;  // X -..-
         {3'd4, 4'b1011}: idx = 5'd24;  // Y -.--
         {3'd4, 4'b1100}: idx = 5'd25;  // Z --..
         default:         hit = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         pat_q    <= '0;
         len_q    <= '0;
         ovf_q    <= 1'b0;
         letter_q <= '0;
         valid_q  <= 1'b0;
         error_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         error_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (key_sync_q) begin
                  state_q <= S_MARK;
                  cnt_q   <= 32'd1;
                  pat_q   <= '0;
                  len_q   <= '0;
                  ovf_q   <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            S_MARK: begin
               if (!key_sync_q) begin
                  // A fifth element cannot be stored. Remember that it
                  // happened so the letter is rejected at decode.
                  if (len_q == 3'd4) begin
                     ovf_q <= 1'b1;
                  end else begin
                     pat_q <= {pat_q[2:0], is_dash};
                     len_q <= len_q + 3'd1;
                  end
                  state_q <= S_SPACE;
                  cnt_q   <= 32'd1;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            S_SPACE: begin
               if (key_sync_q) begin
                  state_q <= S_MARK;
                  cnt_q   <= 32'd1;
               end else begin
                  cnt_q <= cnt_d;
                  if (cnt_d == THRESH) begin
                     state_q <= S_DECODE;
                  end
               end
            end
            S_DECODE: begin
               if (!ovf_q && hit) begin
                  letter_q <= idx;
                  valid_q  <= 1'b1;
               end else begin
                  error_q <= 1'b1;
               end
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign letter_o       = letter_q;
   assign letter_valid_o = valid_q;
   assign error_o        = error_q;
   assign busy_o         = busy_q;

endmodule

// File: tb/tb_morse_receiver.sv
// -----------------------------------------------------------------------------
// tb_morse_receiver
//   Drives morse_receiver (UNIT_CYCLES=4, T=8) with run-length keying
//   waveforms: directed cases plus random letters and random element
//   strings. A letter-level model turns each waveform into the expected
//   output per cycle. It classifies marks, looks up the element string in
//   a Morse table, and places each pulse T+3 cycles after the ending
//   space starts. One negedge process compares every cycle.
// -----------------------------------------------------------------------------
module tb_morse_receiver;

   localparam int UNIT = 4;
   localparam int T    = 2 * UNIT;
   localparam int MAXC = 40000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_in = 1'b0;
   logic [4:0] letter;
   logic       letter_valid;
   logic       error;
   logic       busy;

   morse_receiver #(.UNIT_CYCLES(UNIT)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .key_in_i      (key_in),
      .letter_o      (letter),
      .letter_valid_o(letter_valid),
      .error_o       (error),
      .busy_o        (busy)
   );

   always #5 clk = ~clk;

   // Interval c is the time between posedge c and posedge c+1.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected outputs per interval.
   bit         exp_valid [MAXC];
   bit         exp_err   [MAXC];
   bit         exp_busy  [MAXC];
   logic [4:0] exp_idx   [MAXC];

   string codes [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                         "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                         "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                         "-.--", "--.."};

   // Runs alternate mark/space and start with a mark at interval base.
   // The synchronizer adds 2 cycles, and the decode step plus the
   // registered pulse add T+1 after the T-th low cycle. So a pulse lands
   // at (space start)+T+3, and busy covers (first mark start)+3 up to the
   // pulse, exclusive.
   task automatic model_runs(input int base, input int runs[$]);
      int    t = base;
      bit    in_letter = 1'b0;
      int    start = 0;
      string el = "";
      foreach (runs[i]) begin
         if (i % 2 == 0) begin
            if (!in_letter) begin
               in_letter = 1'b1;
               start = t;
               el = "";
            end
            el = {el, (runs[i] >= T) ? "-" : "."};
         end else if (in_letter && runs[i] >= T) begin
            int p = t + T + 3;
            int found = -1;
            for (int k = 0; k < 26; k++) if (codes[k] == el) found = k;
            if (p < MAXC) begin
               if (found < 0) exp_err[p] = 1'b1;
               else begin
                  exp_valid[p] = 1'b1;
                  exp_idx[p]   = 5'(found);
               end
               for (int c = start + 3; c < p; c++) exp_busy[c] = 1'b1;
            end
            in_letter = 1'b0;
         end
         t += runs[i];
      end
   endtask

   int last_base = 0;

   task automatic send(input int runs[$]);
      @(posedge clk);
      #1;
      last_base = cyc;
      model_runs(cyc, runs);
      foreach (runs[i]) begin
         for (int k = 0; k < runs[i]; k++) begin
            if (!(i == 0 && k == 0)) begin
               @(posedge clk);
               #1;
            end
            key_in = (i % 2 == 0);
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         key_in = 1'b0;
      end
   endtask

   // Observed pulses, used by the literal checks.
   typedef struct {
      int         c;
      logic [4:0] l;
   } pulse_t;
   pulse_t q_v[$];
   int     q_e[$];

   bit         chk_en = 1'b0;
   logic [4:0] ml = 5'd0;

   always @(negedge clk) begin
      if (!rst_n) ml = 5'd0;
      if (rst_n && letter_valid) q_v.push_back('{c: cyc, l: letter});
      if (rst_n && error) q_e.push_back(cyc);
      if (chk_en && rst_n && cyc < MAXC) begin
         if (exp_valid[cyc]) ml = exp_idx[cyc];
         check($sformatf("outputs{valid,err,busy,letter}@%0d", cyc),
               {letter_valid, error, busy, letter},
               {exp_valid[cyc], exp_err[cyc], exp_busy[cyc], ml});
      end
   end

   initial begin
      int    runs[$];
      string el;

      // Reset state
      rst_n = 1'b0;
      key_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset outputs", {letter_valid, error, busy, letter}, 0);
      rst_n = 1'b1;
      chk_en = 1'b1;
      idle(4);

      // A: .-
      q_v.delete(); q_e.delete();
      send('{4, 4, 12, 12});
      check("model pins A", {exp_valid[last_base + 31], exp_idx[last_base + 31]}, {1'b1, 5'd0});
      idle(6);
      check("A valid count", q_v.size(), 1);
      check("A error count", q_e.size(), 0);
      if (q_v.size() > 0) begin
         check("A letter", q_v[0].l, 0);
         check("A pulse offset", q_v[0].c - last_base, 31);
      end

      // Q then E back-to-back
      q_v.delete(); q_e.delete();
      send('{12, 4, 12, 4, 4, 4, 12, 12, 4, 12});
      idle(6);
      check("QE valid count", q_v.size(), 2);
      if (q_v.size() == 2) begin
         check("Q letter", q_v[0].l, 16);
         check("E letter", q_v[1].l, 4);
         check("QE pulse spacing", q_v[1].c - q_v[0].c, 16);
      end

      // Classification boundaries
      q_v.delete();
      send('{7, 8});
      idle(6);
      if (q_v.size() > 0) begin
         check("mark T-1 is dot -> E", q_v[0].l, 4);
         check("space T ends letter", q_v[0].c - last_base, 18);
      end
      send('{8, 8});
      idle(6);
      send('{4, 7, 4, 8});
      idle(6);
      check("boundary valid count", q_v.size(), 3);
      if (q_v.size() == 3) begin
         check("mark T is dash -> T", q_v[1].l, 19);
         check("space T-1 is gap -> I", q_v[2].l, 8);
      end

      // Unmapped ..-- and five dots
      q_v.delete(); q_e.delete();
      send('{4, 4, 4, 4, 12, 4, 12, 12});
      idle(6);
      send('{4, 4, 4, 4, 4, 4, 4, 4, 4, 12});
      idle(6);
      check("unmapped error count", q_e.size(), 2);
      check("unmapped valid count", q_v.size(), 0);
      check("letter retained", letter, 8);

      // Reset mid-letter
      q_v.delete(); q_e.delete();
      chk_en = 1'b0;
      for (int k = 0; k < 15; k++) begin
         @(posedge clk);
         #1;
         key_in = (k < 12);
      end
      check("busy before reset", busy, 1);
      rst_n = 1'b0;
      #1;
      check("async reset clears", {letter_valid, error, busy, letter}, 0);
      repeat (3) begin
         @(negedge clk);
         check("outputs in reset", {letter_valid, error, busy, letter}, 0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk_en = 1'b1;
      send('{4, 12});
      idle(6);
      check("post-reset valid count", q_v.size(), 1);
      check("post-reset error count", q_e.size(), 0);
      if (q_v.size() > 0) check("post-reset letter", q_v[0].l, 4);

      // Very long mark
      q_v.delete();
      send('{1000, 8});
      idle(6);
      check("long mark valid count", q_v.size(), 1);
      if (q_v.size() > 0) check("long mark -> T", q_v[0].l, 19);

      // Random letters and random element strings
      for (int n = 0; n < 60; n++) begin
         runs.delete();
         if ($urandom_range(9) < 7) begin
            el = codes[$urandom_range(25)];
         end else begin
            el = "";
            for (int k = 0, m = $urandom_range(5, 1); k < m; k++)
               el = {el, ($urandom_range(1) == 1) ? "-" : "."};
         end
         for (int k = 0; k < el.len(); k++) begin
            runs.push_back((el[k] == "-") ? int'($urandom_range(3 * T, T)) : int'($urandom_range(T - 1, 1)));
            runs.push_back((k == el.len() - 1) ? int'($urandom_range(3 * T, T + 2)) : int'($urandom_range(T - 1, 1)));
         end
         send(runs);
      end
      idle(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
